vram_port_arbiter: RTL and testbench
====================================

# vram_port_arbiter

Shares port A of the 16-bit × 64K dual-port video block RAM between the display scan-out fetcher and the game-logic (CPU) requester. Each cycle it grants at most one access, drives the RAM port, and routes read data back to the owner with a valid pulse. Display fetches have priority, and a starvation counter guarantees the CPU a slot. Port B of the RAM is not touched.

## Interface
- `AW`, 16: address width; matches RAM `addra`.
- `DW`, 16: data width; matches RAM `dina`/`douta`.
- `RD_LAT`, 1: RAM read latency in cycles. Legal values are 1 or 2.
- `STARVE_MAX`, 8: number of consecutive cycles the CPU may be refused before it gets priority. Legal range is 1..255.

Ports:
- `clka` in 1: the single clock, shared with RAM port A.
- `rst_n` in 1: asynchronous, active-low reset.
- `disp_req` in 1: display read request. Held, with its address, until granted.
- `disp_addr` in AW: display read address.
- `disp_gnt` out 1: combinational grant to the display.
- `disp_rdata` out DW: display read data; valid only while `disp_rvalid`.
- `disp_rvalid` out 1: one-cycle pulse per accepted display read.
- `cpu_req` in 1: CPU request. Held, with address/data/we, until granted.
- `cpu_we` in 1: 1 = write, 0 = read.
- `cpu_addr` in AW: CPU address.
- `cpu_wdata` in DW: CPU write data.
- `cpu_gnt` out 1: combinational grant to the CPU.
- `cpu_rdata` out DW: CPU read data.
- `cpu_rvalid` out 1: one-cycle pulse per accepted CPU read; never pulses for writes.
- `mem_en` out 1: to RAM `ena`.
- `mem_we` out 1: to RAM `wea`.
- `mem_addr` out AW: to RAM `addra`.
- `mem_din` out DW: to RAM `dina`.
- `mem_dout` in DW: from RAM `douta`.

## Operation
- Acceptance: a request is accepted on a rising edge where `req && gnt` was high.
- Grant rule (combinational, from current requests and starvation count):
  - Only one requester active: that requester is granted.
  - Both active and `starve_cnt == STARVE_MAX`: the CPU is granted.
  - Both active otherwise: the display is granted.
- Grants are mutually exclusive.
- RAM drive:
  - `mem_en = disp_gnt | cpu_gnt`.
  - `mem_we = cpu_gnt & cpu_we`.
  - `mem_addr` and `mem_din` are muxed from the granted requester.
  - When idle, `mem_addr` and `mem_din` are 0.
- Starvation counter `starve_cnt`, 8-bit, saturating at `STARVE_MAX`:
  - +1 each cycle that `cpu_req && !cpu_gnt`.
  - Cleared on CPU acceptance.
  - Cleared when `cpu_req` is low.
- Read return: each accepted read pushes a {valid, id} tag into an `RD_LAT`-deep shift register.
  - At the output end the tag raises the owner's `rvalid`.
  - `disp_rdata` and `cpu_rdata` both carry `mem_dout` combinationally; `rvalid` qualifies them.
- Reset (async assert, sync release):
  - `starve_cnt = 0`; tag pipe cleared.
  - `disp_rvalid = cpu_rvalid = 0`.
  - Grants and `mem_en`/`mem_we` are 0 while `rst_n` is low.
  - Reads in flight when reset asserts are dropped and never produce `rvalid`.

## Timing
- Grant is zero-latency: requests issued back-to-back with held `req` can be accepted on every edge.
- Read latency: `rvalid` is high during the cycle following the `RD_LAT`-th rising edge counted from, and including, the acceptance edge.
  - `RD_LAT=1`: the cycle immediately after acceptance.
- Throughput: one access per cycle total. Return tags are pipelined, so there is no bubble between reads.
- Write followed by read of the same address on the next edge returns the new data (RAM write-first on port A).
- Worst-case CPU wait with the display continuously requesting: `STARVE_MAX` cycles refused, then granted on the next edge.

## Structure
- Package `vram_arb_pkg` holds:
  - the requester-ID enum: `ID_DISP`, `ID_CPU`;
  - the tag struct {valid, id};
  - the defaults `AW`/`DW`.
- Sub-module `rd_tag_pipe` is the `RD_LAT`-deep tag shift register with async reset. It is instantiated once.
- Arbitration and the counter live in the top module.

## Test plan
- Display-only reads, `RD_LAT=1`: `disp_req` held at addresses 0x0001..0x0004 on consecutive edges, RAM preloaded with 0xA001..0xA004 → four consecutive `disp_rvalid` cycles with data 0xA001..0xA004 in order, `cpu_rvalid` stays 0.
- CPU write then read: write 0x1234 to 0x0010, then read 0x0010 → no `rvalid` for the write; `cpu_rvalid` one cycle later with 0x1234.
- Starvation, `STARVE_MAX=8`: display and CPU both requesting continuously → CPU refused for 8 cycles, granted on the 9th, counter back to 0, then display granted again.
- Simultaneous first request with `starve_cnt=0` → display granted; `cpu_gnt` is 0 that cycle.
- `RD_LAT=2`: interleaved display/CPU reads → each `rvalid` lands exactly 2 cycles after its acceptance, routed to the correct owner.
- Reset mid-read: assert `rst_n` low one cycle after a CPU read is accepted → no `cpu_rvalid` ever, all outputs 0 during reset, and normal operation on the first edge after release.

Source files
------------

// File: rtl/vram_arb_pkg.sv
// Shared types and defaults for the VRAM port-A arbiter.
// Requester IDs tag each read so that its return data reaches the right owner.
package vram_arb_pkg;

    localparam int DEF_AW = 16;
    localparam int DEF_DW = 16;

    typedef enum logic {
        ID_DISP = 1'b0,
        ID_CPU  = 1'b1
    } req_id_e;

    typedef struct packed {
        logic    valid;
        req_id_e id;
    } rd_tag_t;

    localparam rd_tag_t TAG_IDLE = '{valid: 1'b0, id: ID_DISP};

endpackage

// File: rtl/rd_tag_pipe.sv
// Read-return tag delay line. It is as deep as the RAM read latency, so each tag
// reaches the output in the same cycle as the matching douta word.
module rd_tag_pipe
    import vram_arb_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic    clk,
    input  logic    rst_n,
    input  rd_tag_t tag_in,
    output rd_tag_t tag_out
);

    rd_tag_t pipe [RD_LAT];

    // An asynchronous clear drops every read in flight, so it never returns a valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) pipe[i] <= TAG_IDLE;
        end else begin
            pipe[0] <= tag_in;
            for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign tag_out = pipe[RD_LAT-1];

endmodule

// File: rtl/vram_port_arbiter.sv
// Port-A arbiter for the video block RAM. Display fetches have priority, and a
// saturating starvation counter guarantees the CPU an access slot.
module vram_port_arbiter
    import vram_arb_pkg::*;
#(
    parameter int AW         = DEF_AW,
    parameter int DW         = DEF_DW,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 8
) (
    input  logic          clka,
    input  logic          rst_n,
    input  logic          disp_req,
    input  logic [AW-1:0] disp_addr,
    output logic          disp_gnt,
    output logic [DW-1:0] disp_rdata,
    output logic          disp_rvalid,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_rvalid,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout
);

    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    // Handshake: a requester holds req and its payload stable. The request is
    // accepted on the rising edge where req && gnt is high. gnt may then drop.
    logic [7:0] starve_cnt;
    logic       cpu_wins;
    rd_tag_t    tag_in;
    rd_tag_t    tag_out;

    assign cpu_wins = !disp_req || (starve_cnt == STARVE_LIM);
    assign cpu_gnt  = rst_n && cpu_req && cpu_wins;
    assign disp_gnt = rst_n && disp_req && !cpu_gnt;

    assign mem_en   = disp_gnt || cpu_gnt;
    assign mem_we   = cpu_gnt && cpu_we;

    always_comb begin
        mem_addr = '0;
        mem_din  = '0;
        if (cpu_gnt) begin
            mem_addr = cpu_addr;
            mem_din  = cpu_wdata;
        end else if (disp_gnt) begin
            mem_addr = disp_addr;
        end
    end

    // The counter restarts whenever the CPU is served or withdraws its request.
    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (!cpu_req || cpu_gnt) begin
            starve_cnt <= '0;
        end else if (starve_cnt != STARVE_LIM) begin
            starve_cnt <= starve_cnt + 8'd1;
        end
    end

    always_comb begin
        tag_in.valid = disp_gnt || (cpu_gnt && !cpu_we);
        tag_in.id    = cpu_gnt ? ID_CPU : ID_DISP;
    end

    rd_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_tag_pipe (
        .clk     (clka),
        .rst_n   (rst_n),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    assign disp_rvalid = tag_out.valid && (tag_out.id == ID_DISP);
    assign cpu_rvalid  = tag_out.valid && (tag_out.id == ID_CPU);
    assign disp_rdata  = mem_dout;
    assign cpu_rdata   = mem_dout;

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Directed bench: a RD_LAT=1 arbiter and a RD_LAT=2 arbiter share one stimulus,
// and each has its own write-first RAM model and its own return scoreboard.
module tb_vram_port_arbiter;

    localparam int L1 = 1;
    localparam int L2 = 2;

    logic        clka = 1'b0;
    logic        rst_n;
    logic        disp_req;
    logic [15:0] disp_addr;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;

    logic        d1_disp_gnt, d1_disp_rvalid, d1_cpu_gnt, d1_cpu_rvalid, d1_en, d1_we;
    logic [15:0] d1_disp_rdata, d1_cpu_rdata, d1_addr, d1_din, d1_dout;
    logic        d2_disp_gnt, d2_disp_rvalid, d2_cpu_gnt, d2_cpu_rvalid, d2_en, d2_we;
    logic [15:0] d2_disp_rdata, d2_cpu_rdata, d2_addr, d2_din, d2_dout;

    logic [15:0] ram1 [65536];
    logic [15:0] ram2 [65536];
    logic [15:0] r1_q, r2_q, r2_qq;

    // Scoreboard entry: {accept_cycle[31:0], owner_is_cpu, data[15:0]}
    logic [48:0] exp_q[$];
    logic [48:0] exp2_q[$];

    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    logic [15:0] wd [4];

    always #5 clka = ~clka;
    always @(posedge clka) cyc <= cyc + 1;

    vram_port_arbiter #(.AW(16), .DW(16), .RD_LAT(L1), .STARVE_MAX(8)) u_dut (
        .clka(clka), .rst_n(rst_n),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(d1_disp_gnt),
        .disp_rdata(d1_disp_rdata), .disp_rvalid(d1_disp_rvalid),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(d1_cpu_gnt), .cpu_rdata(d1_cpu_rdata), .cpu_rvalid(d1_cpu_rvalid),
        .mem_en(d1_en), .mem_we(d1_we), .mem_addr(d1_addr), .mem_din(d1_din),
        .mem_dout(d1_dout)
    );

    vram_port_arbiter #(.AW(16), .DW(16), .RD_LAT(L2), .STARVE_MAX(8)) u_dut2 (
        .clka(clka), .rst_n(rst_n),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(d2_disp_gnt),
        .disp_rdata(d2_disp_rdata), .disp_rvalid(d2_disp_rvalid),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(d2_cpu_gnt), .cpu_rdata(d2_cpu_rdata), .cpu_rvalid(d2_cpu_rvalid),
        .mem_en(d2_en), .mem_we(d2_we), .mem_addr(d2_addr), .mem_din(d2_din),
        .mem_dout(d2_dout)
    );

    // Write-first synchronous RAM models with 1 and 2 cycles of read latency.
    always @(posedge clka) begin
        if (d1_en) begin
            if (d1_we) ram1[d1_addr] <= d1_din;
            r1_q <= d1_we ? d1_din : ram1[d1_addr];
        end
        if (d2_en) begin
            if (d2_we) ram2[d2_addr] <= d2_din;
            r2_q <= d2_we ? d2_din : ram2[d2_addr];
        end
        r2_qq <= r2_q;
    end
    assign d1_dout = r1_q;
    assign d2_dout = r2_qq;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Return monitors: every rvalid must match the oldest expected read for that DUT.
    always @(negedge clka) begin
        logic [48:0] e;
        if (d1_disp_rvalid || d1_cpu_rvalid) begin
            if (exp_q.size() == 0) begin
                check("d1_unexpected_rvalid", {d1_disp_rvalid, d1_cpu_rvalid}, 2'b00);
            end else begin
                e = exp_q.pop_front();
                check("d1_rvalid_owner", {d1_disp_rvalid, d1_cpu_rvalid}, e[16] ? 2'b01 : 2'b10);
                check("d1_rdata", e[16] ? d1_cpu_rdata : d1_disp_rdata, e[15:0]);
                check("d1_latency", cyc, e[48:17] + L1 - 1);
            end
        end
    end

    always @(negedge clka) begin
        logic [48:0] e;
        if (d2_disp_rvalid || d2_cpu_rvalid) begin
            if (exp2_q.size() == 0) begin
                check("d2_unexpected_rvalid", {d2_disp_rvalid, d2_cpu_rvalid}, 2'b00);
            end else begin
                e = exp2_q.pop_front();
                check("d2_rvalid_owner", {d2_disp_rvalid, d2_cpu_rvalid}, e[16] ? 2'b01 : 2'b10);
                check("d2_rdata", e[16] ? d2_cpu_rdata : d2_disp_rdata, e[15:0]);
                check("d2_latency", cyc, e[48:17] + L2 - 1);
            end
        end
    end

    task automatic chk_bus(input string p, input logic dg, input logic cg, input logic en,
                           input logic we, input logic [15:0] a, input logic [15:0] din,
                           input logic edg, input logic ecg);
        logic [15:0] ea;
        ea = edg ? disp_addr : (ecg ? cpu_addr : 16'h0000);
        check({p, "_disp_gnt"}, dg, edg);
        check({p, "_cpu_gnt"}, cg, ecg);
        check({p, "_mem_en"}, en, edg | ecg);
        check({p, "_mem_we"}, we, ecg & cpu_we);
        check({p, "_mem_addr"}, a, ea);
        check({p, "_mem_din"}, din, ecg ? cpu_wdata : 16'h0000);
    endtask

    task automatic chk_reset_outputs();
        chk_bus("rst_d1", d1_disp_gnt, d1_cpu_gnt, d1_en, d1_we, d1_addr, d1_din, 1'b0, 1'b0);
        chk_bus("rst_d2", d2_disp_gnt, d2_cpu_gnt, d2_en, d2_we, d2_addr, d2_din, 1'b0, 1'b0);
        check("rst_rvalids", {d1_disp_rvalid, d1_cpu_rvalid, d2_disp_rvalid, d2_cpu_rvalid}, 4'h0);
    endtask

    // Called just after a negedge with the inputs already driven: check the grant
    // and RAM drive, queue the expected read return, then advance one cycle.
    task automatic clk_step(input logic edg, input logic ecg, input logic [15:0] edata);
        #1;
        chk_bus("d1", d1_disp_gnt, d1_cpu_gnt, d1_en, d1_we, d1_addr, d1_din, edg, ecg);
        chk_bus("d2", d2_disp_gnt, d2_cpu_gnt, d2_en, d2_we, d2_addr, d2_din, edg, ecg);
        if (edg || (ecg && !cpu_we)) begin
            exp_q.push_back({cyc + 1, ecg, edata});
            exp2_q.push_back({cyc + 1, ecg, edata});
        end
        @(posedge clka);
        @(negedge clka);
    endtask

    task automatic drive(input logic dr, input logic [15:0] da, input logic cr,
                         input logic cw, input logic [15:0] ca, input logic [15:0] cd);
        disp_req  = dr;
        disp_addr = da;
        cpu_req   = cr;
        cpu_we    = cw;
        cpu_addr  = ca;
        cpu_wdata = cd;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        repeat (n) clk_step(1'b0, 1'b0, 16'h0);
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) begin
            ram1[a] = 16'h0000;
            ram2[a] = 16'h0000;
        end
        for (int a = 1; a <= 4; a++) begin
            ram1[a] = 16'hA000 + 16'(a);
            ram2[a] = 16'hA000 + 16'(a);
        end

        // Reset with both requests raised: nothing may be granted.
        rst_n = 1'b0;
        drive(1'b1, 16'h0001, 1'b1, 1'b1, 16'h0010, 16'hFFFF);
        repeat (2) @(negedge clka);
        #1;
        chk_reset_outputs();
        check("rst_starve_cnt", u_dut.starve_cnt, 8'd0);
        rst_n = 1'b1;
        drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        @(negedge clka);

        // Display-only back-to-back reads.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 16'(i + 1), 1'b0, 1'b0, 16'h0, 16'h0);
            clk_step(1'b1, 1'b0, 16'hA001 + 16'(i));
        end
        idle(3);

        // CPU write, then read of the same address on the next edge.
        drive(1'b0, 16'h0, 1'b1, 1'b1, 16'h0010, 16'h1234);
        clk_step(1'b0, 1'b1, 16'h0000);
        drive(1'b0, 16'h0, 1'b1, 1'b0, 16'h0010, 16'h0000);
        clk_step(1'b0, 1'b1, 16'h1234);
        idle(3);

        // Contention: display wins while the CPU starves, then the CPU gets the slot.
        drive(1'b1, 16'h0002, 1'b1, 1'b0, 16'h0010, 16'h0000);
        for (int i = 0; i < 8; i++) begin
            check("starve_cnt_rising", u_dut.starve_cnt, 8'(i));
            clk_step(1'b1, 1'b0, 16'hA002);
        end
        check("starve_cnt_sat", u_dut.starve_cnt, 8'd8);
        clk_step(1'b0, 1'b1, 16'h1234);
        check("starve_cnt_cleared", u_dut.starve_cnt, 8'd0);
        clk_step(1'b1, 1'b0, 16'hA002);
        idle(3);

        // Random CPU writes, then display and CPU reads interleaved every edge.
        for (int i = 0; i < 4; i++) begin
            wd[i] = 16'($urandom_range(0, 16'hFFFF));
            drive(1'b0, 16'h0, 1'b1, 1'b1, 16'h0020 + 16'(i), wd[i]);
            clk_step(1'b0, 1'b1, 16'h0000);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 16'(i + 1), 1'b0, 1'b0, 16'h0, 16'h0);
            clk_step(1'b1, 1'b0, 16'hA001 + 16'(i));
            drive(1'b0, 16'h0, 1'b1, 1'b0, 16'h0020 + 16'(i), 16'h0);
            clk_step(1'b0, 1'b1, wd[i]);
        end
        idle(3);

        // Reset right after a CPU read is accepted: that read must never return.
        drive(1'b0, 16'h0, 1'b1, 1'b0, 16'h0010, 16'h0000);
        #1;
        check("pre_rst_cpu_gnt", {d1_cpu_gnt, d2_cpu_gnt}, 2'b11);
        @(posedge clka);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        exp2_q.delete();
        drive(1'b1, 16'h0003, 1'b1, 1'b0, 16'h0010, 16'h0000);
        repeat (3) begin
            @(negedge clka);
            #1;
            chk_reset_outputs();
        end
        rst_n = 1'b1;
        drive(1'b1, 16'h0004, 1'b0, 1'b0, 16'h0, 16'h0);
        clk_step(1'b1, 1'b0, 16'hA004);
        idle(4);

        check("d1_queue_drained", exp_q.size(), 0);
        check("d2_queue_drained", exp2_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
